// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   SEQ_1011   - default pattern, MSB is the first bit received
//   OVL_ON/OFF - OVERLAP parameter values
//   fill_width - width of the accepted-bit counter that saturates at pat_len
package seq_det_pkg;

  localparam logic [3:0] SEQ_1011 = 4'b1011;

  localparam bit OVL_ON  = 1'b1;
  localparam bit OVL_OFF = 1'b0;

  // Enough bits to hold the values 0..pat_len inclusive.
  function automatic int unsigned fill_width(input int unsigned pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i   - rising-edge clock
//   rst_ni  - asynchronous active-low reset, count goes to 0
//   inc_i   - add one unless already at the all-ones maximum
//   clr_i   - synchronous clear; wins over a same-cycle inc_i
//   count_o - current count
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/seq_det_moore_param.sv
// Parametrised Moore serial pattern detector with runtime-loadable pattern.
//   clock        - rising-edge clock
//   reset_n      - asynchronous active-low reset
//   sequence_in  - serial data bit, sampled only when in_valid is 1
//   in_valid     - qualifies sequence_in
//   pattern_load - load pattern_in, flush history; wins over in_valid
//   pattern_in   - new pattern, MSB is the first bit received
//   count_clr    - synchronous clear of detect_count, wins over a same-cycle hit
//   detector_out - registered match flag, high the cycle after the final bit
//   detect_count - saturating number of matches
module seq_det_moore_param
  import seq_det_pkg::*;
#(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(SEQ_1011),
  parameter bit                 OVERLAP = OVL_ON,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               sequence_in,
  input  logic               in_valid,
  input  logic               pattern_load,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               count_clr,
  output logic               detector_out,
  output logic [CNT_W-1:0]   detect_count
);

  localparam int unsigned       FillW   = fill_width(PAT_LEN);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_LEN);

  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] nhist;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [FillW-1:0]   nfill;
  logic               detected_q, detected_d;
  logic               hit;

  always_comb begin
    nhist      = {hist_q[PAT_LEN-2:0], sequence_in};
    nfill      = (fill_q == FillMax) ? fill_q : fill_q + FillW'(1);
    hit        = 1'b0;
    hist_d     = hist_q;
    fill_d     = fill_q;
    pat_d      = pat_q;
    detected_d = detected_q;

    if (pattern_load) begin
      // Same-cycle sample is dropped; the new pattern starts from an empty history.
      pat_d      = pattern_in;
      hist_d     = '0;
      fill_d     = '0;
      detected_d = 1'b0;
    end else if (in_valid) begin
      // The fill gate stops zero-initialised history from matching an all-zero pattern.
      hit        = (nfill == FillMax) && (nhist == pat_q);
      hist_d     = nhist;
      detected_d = hit;
      fill_d     = (hit && (OVERLAP == OVL_OFF)) ? '0 : nfill;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hist_q     <= '0;
      fill_q     <= '0;
      pat_q      <= PATTERN;
      detected_q <= 1'b0;
    end else begin
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      pat_q      <= pat_d;
      detected_q <= detected_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_count (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .inc_i   (hit),
    .clr_i   (count_clr),
    .count_o (detect_count)
  );

  assign detector_out = detected_q;

endmodule
